// File: rtl/tx_word_arbiter.sv
// tx_word_arbiter
// Round-robin arbiter that shares the 16-bit word-send side of a UART
// transceiver among NUM_REQ requesters. Each granted word may be preceded
// by a header word {HDR_TAG, id}. A watchdog aborts a word whose
// data_send_done never arrives. Every output comes straight from a flop.

module tx_word_arbiter #(
    parameter int         NUM_REQ     = 4,
    parameter int         HDR_EN      = 1,
    parameter logic [7:0] HDR_TAG     = 8'hA5,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic [NUM_REQ-1:0]     req_done,
    output logic                   req_err,
    output logic [15:0]            data_send,
    output logic                   data_send_valid,
    input  logic                   data_send_done,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   clear_err
);

    // A single requester still needs a 1-bit id field.
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic PH_HDR = 1'b0;
    localparam logic PH_PLD = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GRANT  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [15:0]        word_q, word_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_grant_q, req_grant_d;
    logic [NUM_REQ-1:0] req_done_q, req_done_d;
    logic               req_err_q, req_err_d;
    logic [15:0]        data_send_q, data_send_d;
    logic               data_send_valid_q, data_send_valid_d;
    logic               busy_q, busy_d;
    logic               timeout_err_q, timeout_err_d;

    logic               win_found_s;
    logic [ID_W-1:0]    win_id_s;
    logic [15:0]        hdr_word_s;

    // Round-robin search: first pending requester after the last winner.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = ptr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found_s && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                win_found_s = 1'b1;
                win_id_s    = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    assign hdr_word_s = {HDR_TAG, 8'(id_q)};

    // Next-state and next-output logic; outputs are computed for the state being entered.
    always_comb begin
        state_d           = state_q;
        ptr_d             = ptr_q;
        id_d              = id_q;
        word_d            = word_q;
        phase_d           = phase_q;
        cnt_d             = cnt_q;
        req_grant_d       = '0;
        req_done_d        = '0;
        req_err_d         = 1'b0;
        data_send_d       = data_send_q;
        data_send_valid_d = 1'b0;

        // A timeout raised below in the same cycle overrides the clear.
        if (clear_err) begin
            timeout_err_d = 1'b0;
        end else begin
            timeout_err_d = timeout_err_q;
        end

        case (state_q)
            S_IDLE: begin
                if (win_found_s) begin
                    state_d               = S_GRANT;
                    ptr_d                 = win_id_s;
                    id_d                  = win_id_s;
                    word_d                = req_data[16*int'(win_id_s) +: 16];
                    phase_d               = (HDR_EN != 0) ? PH_HDR : PH_PLD;
                    req_grant_d[win_id_s] = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                state_d           = S_ISSUE;
                data_send_d       = (phase_q == PH_HDR) ? hdr_word_s : word_q;
                data_send_valid_d = 1'b1;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // done is checked first so a done on the expiry cycle is not an error.
                if (data_send_done) begin
                    if (phase_q == PH_HDR) begin
                        state_d           = S_ISSUE;
                        phase_d           = PH_PLD;
                        data_send_d       = word_q;
                        data_send_valid_d = 1'b1;
                    end else begin
                        state_d          = S_FINISH;
                        req_done_d[id_q] = 1'b1;
                        req_err_d        = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d          = S_FINISH;
                    req_done_d[id_q] = 1'b1;
                    req_err_d        = 1'b1;
                    timeout_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset points the pointer so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= S_IDLE;
            ptr_q             <= ID_W'(NUM_REQ - 1);
            id_q              <= '0;
            word_q            <= 16'h0000;
            phase_q           <= PH_HDR;
            cnt_q             <= '0;
            req_grant_q       <= '0;
            req_done_q        <= '0;
            req_err_q         <= 1'b0;
            data_send_q       <= 16'h0000;
            data_send_valid_q <= 1'b0;
            busy_q            <= 1'b0;
            timeout_err_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            id_q              <= id_d;
            word_q            <= word_d;
            phase_q           <= phase_d;
            cnt_q             <= cnt_d;
            req_grant_q       <= req_grant_d;
            req_done_q        <= req_done_d;
            req_err_q         <= req_err_d;
            data_send_q       <= data_send_d;
            data_send_valid_q <= data_send_valid_d;
            busy_q            <= busy_d;
            timeout_err_q     <= timeout_err_d;
        end
    end

    assign req_grant       = req_grant_q;
    assign req_done        = req_done_q;
    assign req_err         = req_err_q;
    assign data_send       = data_send_q;
    assign data_send_valid = data_send_valid_q;
    assign busy            = busy_q;
    assign timeout_err     = timeout_err_q;

endmodule
